// File: rtl/sdram_pkg.sv
// Shared SDRAM command definitions: command codes, pin strobe encodings and
// sequencer state type used by the command sequencer and its interface.
package sdram_pkg;

   typedef enum logic [2:0] {
      CMD_NOP = 3'd0,
      CMD_ACT = 3'd1,
      CMD_RD  = 3'd2,
      CMD_WR  = 3'd3,
      CMD_PRE = 3'd4,
      CMD_BST = 3'd5,
      CMD_MRS = 3'd6,
      CMD_REF = 3'd7
   } sdram_cmd_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_GAP  = 1'b1
   } seq_state_e;

   // Strobe triplet order is {RAS_N, CAS_N, WE_N}.
   localparam logic [2:0] PINS_NOP      = 3'b111;
   localparam logic [2:0] PINS_DESELECT = 3'b111;
   localparam int         PRE_ALL_BIT   = 10;

   function automatic logic [2:0] cmd_pins(input sdram_cmd_e cmd);
      logic [2:0] pins;
      case (cmd)
         CMD_NOP: pins = 3'b111;
         CMD_ACT: pins = 3'b011;
         CMD_RD:  pins = 3'b101;
         CMD_WR:  pins = 3'b100;
         CMD_PRE: pins = 3'b010;
         CMD_BST: pins = 3'b110;
         CMD_MRS: pins = 3'b000;
         CMD_REF: pins = 3'b001;
         default: pins = PINS_NOP;
      endcase
      return pins;
   endfunction

endpackage

// File: rtl/sdram_cmd_sequencer_if.sv
// Scheduler-side request bus of the SDRAM command sequencer: command
// valid/ready handshake plus the level refresh request/acknowledge pair.
interface sdram_cmd_sequencer_if #(
   parameter int CS_W   = 1,
   parameter int BA_W   = 2,
   parameter int ADDR_W = 13
);
   import sdram_pkg::*;

   logic              REQ_VALID;
   logic              REQ_READY;
   sdram_cmd_e        REQ_CMD;
   logic [CS_W-1:0]   REQ_CS;
   logic [BA_W-1:0]   REQ_BA;
   logic [ADDR_W-1:0] REQ_ADDR;
   logic              REFRESH_REQ;
   logic              REFRESH_ACK;

   modport master (
      output REQ_VALID, REQ_CMD, REQ_CS, REQ_BA, REQ_ADDR, REFRESH_REQ,
      input  REQ_READY, REFRESH_ACK
   );

   modport slave (
      input  REQ_VALID, REQ_CMD, REQ_CS, REQ_BA, REQ_ADDR, REFRESH_REQ,
      output REQ_READY, REFRESH_ACK
   );

endinterface

// File: rtl/sdram_gap_counter.sv
// Loadable down-counter holding the remaining command spacing; it stops at
// zero and reports when the spacing has fully elapsed.
module sdram_gap_counter #(
   parameter int CNT_W = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: a load wins, otherwise count down and stick at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sdram_cmd_sequencer.sv
// SDRAM command sequencer: arbitrates refresh against scheduler commands,
// registers the SDRAM command pins and enforces per-command spacing.
module sdram_cmd_sequencer
   import sdram_pkg::*;
#(
   parameter int NUM_CS = 2,
   parameter int CS_W   = 1,
   parameter int BA_W   = 2,
   parameter int ADDR_W = 13,
   parameter int T_RCD  = 3,
   parameter int T_RP   = 3,
   parameter int T_RFC  = 9,
   parameter int T_MRD  = 2,
   parameter int CNT_W  = 4
) (
   input  logic                CLK,
   input  logic                RESET,
   sdram_cmd_sequencer_if.slave req,
   output logic                BUSY,
   output logic [NUM_CS-1:0]   CS_N,
   output logic                RAS_N,
   output logic                CAS_N,
   output logic                WE_N,
   output logic [BA_W-1:0]     BA,
   output logic [ADDR_W-1:0]   SA
);

   // The counter is loaded at the issuing edge, so T-1 yields an accept at N+T.
   localparam logic [CNT_W-1:0] LD_RCD = CNT_W'(T_RCD - 1);
   localparam logic [CNT_W-1:0] LD_RP  = CNT_W'(T_RP - 1);
   localparam logic [CNT_W-1:0] LD_RFC = CNT_W'(T_RFC - 1);
   localparam logic [CNT_W-1:0] LD_MRD = CNT_W'(T_MRD - 1);

   seq_state_e         state_q, state_d;
   logic [NUM_CS-1:0]  cs_n_q, cs_n_d;
   logic [2:0]         pins_q, pins_d;
   logic [BA_W-1:0]    ba_q, ba_d;
   logic [ADDR_W-1:0]  sa_q, sa_d;
   logic               ack_q, ack_d;

   logic               ready_s;
   logic               issue_ref_s;
   logic               accept_s;
   logic [NUM_CS-1:0]  sel_s;
   logic               sel_valid_s;
   logic               load_s;
   logic [CNT_W-1:0]   load_val_s;
   logic [CNT_W-1:0]   gap_cnt_s;
   logic               gap_zero_s;

   sdram_gap_counter #(.CNT_W(CNT_W)) u_gap (
      .clk_i      (CLK),
      .rst_i      (RESET),
      .load_i     (load_s),
      .load_val_i (load_val_s),
      .cnt_o      (gap_cnt_s),
      .zero_o     (gap_zero_s)
   );

   // Rank decode; an out-of-range rank selects nothing and becomes a deselect.
   always_comb begin
      sel_s = '0;
      for (int i = 0; i < NUM_CS; i++) begin
         sel_s[i] = (int'(req.REQ_CS) == i);
      end
      sel_valid_s = |sel_s;
   end

   // Arbitration and next pin values; refresh always beats a pending command.
   always_comb begin
      ready_s     = (state_q == ST_IDLE) && !req.REFRESH_REQ && !RESET;
      issue_ref_s = (state_q == ST_IDLE) && req.REFRESH_REQ;
      accept_s    = req.REQ_VALID && ready_s;
      cs_n_d      = '1;
      pins_d      = PINS_NOP;
      ba_d        = ba_q;
      sa_d        = sa_q;
      ack_d       = 1'b0;
      load_s      = 1'b0;
      load_val_s  = '0;
      if (issue_ref_s) begin
         cs_n_d     = '0;
         pins_d     = cmd_pins(CMD_REF);
         ack_d      = 1'b1;
         load_s     = 1'b1;
         load_val_s = LD_RFC;
      end else if (accept_s && sel_valid_s) begin
         cs_n_d = ~sel_s;
         pins_d = cmd_pins(req.REQ_CMD);
         ba_d   = req.REQ_BA;
         sa_d   = req.REQ_ADDR;
         if (req.REQ_CMD == CMD_PRE) begin
            sa_d[PRE_ALL_BIT] = 1'b1;
         end else begin
            sa_d[PRE_ALL_BIT] = req.REQ_ADDR[PRE_ALL_BIT];
         end
         load_s = 1'b1;
         case (req.REQ_CMD)
            CMD_ACT: load_val_s = LD_RCD;
            CMD_PRE: load_val_s = LD_RP;
            CMD_MRS: load_val_s = LD_MRD;
            CMD_REF: load_val_s = LD_RFC;
            default: load_val_s = '0;
         endcase
      end else begin
         cs_n_d = '1;
         pins_d = PINS_DESELECT;
      end
   end

   // State follows the spacing counter: GAP while a non-zero spacing runs.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (load_s && (load_val_s != '0)) begin
               state_d = ST_GAP;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_GAP: begin
            if (gap_cnt_s <= CNT_W'(1)) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_GAP;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and registered SDRAM pins.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= ST_IDLE;
         cs_n_q  <= '1;
         pins_q  <= PINS_NOP;
         ba_q    <= '0;
         sa_q    <= '0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cs_n_q  <= cs_n_d;
         pins_q  <= pins_d;
         ba_q    <= ba_d;
         sa_q    <= sa_d;
         ack_q   <= ack_d;
      end
   end

   assign req.REQ_READY      = ready_s;
   assign req.REFRESH_ACK    = ack_q;
   assign BUSY               = !gap_zero_s;
   assign CS_N               = cs_n_q;
   assign {RAS_N, CAS_N, WE_N} = pins_q;
   assign BA                 = ba_q;
   assign SA                 = sa_q;

endmodule

// File: tb/tb_sdram_cmd_sequencer.sv
// Scoreboard bench for sdram_cmd_sequencer: the driver queues the expected pin
// cycle for every command or refresh it launches, a negedge monitor checks it.
module tb_sdram_cmd_sequencer;
   import sdram_pkg::*;

   localparam int NUM_CS = 2;
   localparam int CS_W   = 2;
   localparam int BA_W   = 2;
   localparam int ADDR_W = 13;

   typedef struct {
      int          cyc;
      logic [1:0]  cs_n;
      logic [2:0]  pins;
      logic [1:0]  ba;
      logic [12:0] sa;
      logic        ack;
   } exp_t;

   logic CLK = 1'b0;
   logic RESET;
   logic BUSY, RAS_N, CAS_N, WE_N;
   logic [NUM_CS-1:0] CS_N;
   logic [BA_W-1:0]   BA;
   logic [ADDR_W-1:0] SA;

   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;
   exp_t sb[$];
   logic [1:0]  last_ba = 2'd0;
   logic [12:0] last_sa = 13'd0;

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   sdram_cmd_sequencer_if #(.CS_W(CS_W), .BA_W(BA_W), .ADDR_W(ADDR_W)) bus ();

   sdram_cmd_sequencer #(
      .NUM_CS(NUM_CS), .CS_W(CS_W), .BA_W(BA_W), .ADDR_W(ADDR_W),
      .T_RCD(3), .T_RP(3), .T_RFC(9), .T_MRD(2), .CNT_W(4)
   ) dut (
      .CLK(CLK), .RESET(RESET), .req(bus.slave), .BUSY(BUSY), .CS_N(CS_N),
      .RAS_N(RAS_N), .CAS_N(CAS_N), .WE_N(WE_N), .BA(BA), .SA(SA)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push(input int c, input logic [1:0] cs_n, input logic [2:0] pins,
                       input logic [1:0] ba, input logic [12:0] sa, input logic ack);
      exp_t e;
      e.cyc = c; e.cs_n = cs_n; e.pins = pins; e.ba = ba; e.sa = sa; e.ack = ack;
      sb.push_back(e);
      last_ba = ba;
      last_sa = sa;
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic issue(input sdram_cmd_e cmd, input logic [1:0] cs, input logic [1:0] ba,
                        input logic [12:0] addr, input logic on_pins, input logic [1:0] exp_cs_n,
                        input logic [2:0] exp_pins, input logic [12:0] exp_sa, output int acc);
      bus.REQ_VALID = 1'b1;
      bus.REQ_CMD   = cmd;
      bus.REQ_CS    = cs;
      bus.REQ_BA    = ba;
      bus.REQ_ADDR  = addr;
      #1;
      acc = -1;
      for (int w = 0; w < 40; w++) begin
         if (bus.REQ_READY === 1'b1) begin
            acc = cyc + 1;
            if (on_pins) push(acc, exp_cs_n, exp_pins, ba, exp_sa, 1'b0);
            break;
         end
         @(posedge CLK);
         @(negedge CLK);
         #1;
      end
      check("accepted_in_budget", (acc >= 0), 1);
      @(posedge CLK);
      @(negedge CLK);
      bus.REQ_VALID = 1'b0;
   endtask

   // Monitor: every selected cycle must match the head of the scoreboard.
   always @(negedge CLK) begin : monitor
      exp_t e;
      if (RESET === 1'b0) begin
         if (CS_N != 2'b11) begin
            check("sb_has_entry", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("pin_cycle", cyc, e.cyc);
               check("cs_n", CS_N, e.cs_n);
               check("strobes", {RAS_N, CAS_N, WE_N}, e.pins);
               check("ba", BA, e.ba);
               check("sa", SA, e.sa);
               check("refresh_ack", REFRESH_ACK_w(), e.ack);
            end
         end else begin
            check("idle_pins", {RAS_N, CAS_N, WE_N, bus.REFRESH_ACK}, 4'b1110);
         end
      end
   end

   function automatic logic REFRESH_ACK_w();
      return bus.REFRESH_ACK;
   endfunction

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin : driver
      int a0, a1, a2, a3, a4, a5, a6, a7, a8, a9, a10, e1, e2, rel;
      RESET           = 1'b1;
      bus.REQ_VALID   = 1'b1;
      bus.REQ_CMD     = CMD_NOP;
      bus.REQ_CS      = 2'd0;
      bus.REQ_BA      = 2'd0;
      bus.REQ_ADDR    = 13'd0;
      bus.REFRESH_REQ = 1'b0;
      repeat (3) @(negedge CLK);
      check("rst_cs_n", CS_N, 2'b11);
      check("rst_strobes", {RAS_N, CAS_N, WE_N}, 3'b111);
      check("rst_ba", BA, 2'd0);
      check("rst_sa", SA, 13'd0);
      check("rst_ack", bus.REFRESH_ACK, 1'b0);
      check("rst_busy", BUSY, 1'b0);
      check("rst_ready", bus.REQ_READY, 1'b0);
      bus.REQ_VALID = 1'b0;
      RESET = 1'b0;

      // ACT then RD: tRCD spacing.
      issue(CMD_ACT, 2'd1, 2'd2, 13'h0123, 1'b1, 2'b01, 3'b011, 13'h0123, a0);
      check("act_busy", BUSY, 1'b1);
      issue(CMD_RD, 2'd0, 2'd1, 13'h0040, 1'b1, 2'b10, 3'b101, 13'h0040, a1);
      check("trcd_spacing", a1 - a0, 3);

      // RD/WR/BST back-to-back.
      issue(CMD_RD, 2'd1, 2'd0, 13'h0010, 1'b1, 2'b01, 3'b101, 13'h0010, a2);
      check("rd_b2b", a2 - a1, 1);
      issue(CMD_WR, 2'd0, 2'd3, 13'h0200, 1'b1, 2'b10, 3'b100, 13'h0200, a3);
      check("wr_b2b", a3 - a2, 1);
      issue(CMD_BST, 2'd1, 2'd1, 13'h0007, 1'b1, 2'b01, 3'b110, 13'h0007, a4);
      check("bst_b2b", a4 - a3, 1);
      check("ready_after_bst", bus.REQ_READY, 1'b1);

      // PRE forces A10 and holds off for tRP.
      issue(CMD_PRE, 2'd0, 2'd1, 13'h0000, 1'b1, 2'b10, 3'b010, 13'h0400, a5);
      check("pre_b2b", a5 - a4, 1);
      check("pre_busy_1", BUSY, 1'b1);
      @(negedge CLK);
      check("pre_busy_2", BUSY, 1'b1);
      @(negedge CLK);
      check("pre_busy_done", BUSY, 1'b0);
      check("pre_ready_back", bus.REQ_READY, 1'b1);

      // MRS then RD: tMRD spacing.
      issue(CMD_MRS, 2'd1, 2'd0, 13'h0033, 1'b1, 2'b01, 3'b000, 13'h0033, a6);
      issue(CMD_RD, 2'd0, 2'd2, 13'h0101, 1'b1, 2'b10, 3'b101, 13'h0101, a7);
      check("tmrd_spacing", a7 - a6, 2);

      // Out-of-range rank: accepted as a deselect with no spacing.
      issue(CMD_ACT, 2'd3, 2'd2, 13'h0555, 1'b0, 2'b11, 3'b111, 13'h0000, a8);
      check("desel_ready", bus.REQ_READY, 1'b1);
      check("desel_busy", BUSY, 1'b0);
      issue(CMD_RD, 2'd0, 2'd2, 13'h0011, 1'b1, 2'b10, 3'b101, 13'h0011, a9);
      check("desel_no_gap", a9 - a8, 1);

      // Refresh and ACT together: REF first, ACT after tRFC.
      bus.REFRESH_REQ = 1'b1;
      bus.REQ_VALID   = 1'b1;
      bus.REQ_CMD     = CMD_ACT;
      bus.REQ_CS      = 2'd0;
      bus.REQ_BA      = 2'd3;
      bus.REQ_ADDR    = 13'h0ABC;
      #1;
      check("ref_blocks_ready", bus.REQ_READY, 1'b0);
      e1 = cyc + 1;
      push(e1, 2'b00, 3'b001, last_ba, last_sa, 1'b1);
      @(posedge CLK);
      @(negedge CLK);
      bus.REFRESH_REQ = 1'b0;
      check("ref_busy", BUSY, 1'b1);
      issue(CMD_ACT, 2'd0, 2'd3, 13'h0ABC, 1'b1, 2'b10, 3'b011, 13'h0ABC, a10);
      check("trfc_spacing", a10 - e1, 9);

      // Reset two cycles into a refresh gap.
      repeat (3) @(negedge CLK);
      bus.REFRESH_REQ = 1'b1;
      #1;
      e2 = cyc + 1;
      push(e2, 2'b00, 3'b001, last_ba, last_sa, 1'b1);
      @(posedge CLK);
      @(negedge CLK);
      bus.REFRESH_REQ = 1'b0;
      @(posedge CLK);
      @(posedge CLK);
      @(negedge CLK);
      RESET = 1'b1;
      #1;
      check("midgap_rst_busy", BUSY, 1'b0);
      check("midgap_rst_cs_n", CS_N, 2'b11);
      check("midgap_rst_strobes", {RAS_N, CAS_N, WE_N}, 3'b111);
      check("midgap_rst_ba", BA, 2'd0);
      check("midgap_rst_sa", SA, 13'd0);
      check("midgap_rst_ready", bus.REQ_READY, 1'b0);
      last_ba = 2'd0;
      last_sa = 13'd0;
      @(negedge CLK);
      RESET = 1'b0;
      rel = cyc + 1;
      issue(CMD_ACT, 2'd1, 2'd1, 13'h1FFF, 1'b1, 2'b01, 3'b011, 13'h1FFF, a0);
      check("accept_after_reset", a0, rel);

      repeat (4) @(negedge CLK);
      check("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
